alu32_seq: RTL and testbench
============================

# alu32_seq

Sequential 32-bit ALU stage that sits directly downstream of the bitwise units (`my_and`, `my_or`, `my_xor`, `my_nor`) and the adder. It consumes their results, selects and registers one per operation, and adds a multi-cycle unsigned shift-add multiplier. Operations are launched with a start/done handshake. Registered result and flags are the only outputs presented to the register-file writeback.

## Interface
- `WIDTH`, 32, operand/result width; the multiplier iterates `WIDTH` times.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `start`  in  1  launch request; accepted only when `busy`=0.
- `alu_op`  in  3  opcode: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLT (signed), 111 MUL (unsigned).
- `first`  in  WIDTH  operand A; sampled on the accepting edge.
- `second`  in  WIDTH  operand B; sampled on the accepting edge.
- `result`  out  WIDTH  registered result; low half of the product for MUL.
- `result_hi`  out  WIDTH  high half of the product for MUL; 0 for all other ops.
- `overflow`  out  1  signed overflow for ADD/SUB; 0 otherwise.
- `zero`  out  1  1 when `result` and `result_hi` are both 0.
- `busy`  out  1  high from the accepting edge until `done`.
- `done`  out  1  one-cycle pulse; outputs are valid from this cycle on.

## Operation
- FSM states: IDLE, EXEC, MUL.
- IDLE:
  - `start`=1 latches `first`, `second` and `alu_op`, then sets `busy`.
  - Goes to MUL if op=111, otherwise to EXEC.
- EXEC:
  - Computes the selected op from the latched operands.
  - Loads `result`, `result_hi`=0, `overflow`, `zero`.
  - Pulses `done`, then returns to IDLE.
- MUL (64-bit accumulator {hi, lo}, lo initialised to the multiplier):
  - Each cycle: if lo[0]=1, hi += multiplicand, keeping the 33-bit carry.
  - Then the {carry, hi, lo} accumulator shifts right by 1.
  - After `WIDTH` iterations: load `result`=lo, `result_hi`=hi, `zero`; `overflow`=0.
  - Pulses `done`, returns to IDLE.
  - Iteration counter is 6 bits, counting 0..WIDTH-1.
- Width and flag rules:
  - ADD/SUB wrap modulo 2^32.
  - `overflow` = operands' signs agree (SUB: A vs ~B) and result sign differs.
  - SLT result is 32'd0 or 32'd1 from a signed compare; its `overflow` is 0.
- Busy and hold behaviour:
  - `start` while `busy`=1 is ignored: no latch, no queueing.
  - `first`/`second` may change freely after acceptance.
  - Outputs hold their values until the next `done`.
- Reset (any state, including mid-MUL): next state IDLE.
  - `result`, `result_hi`, `overflow`, `zero` ← 0; note `zero` resets to 0, not 1.
  - `busy`, `done` ← 0; counter and accumulator ← 0.
  - An aborted multiply never produces `done`.
- Simultaneous events:
  - `reset` with `start`: `reset` wins.
  - `start` in the cycle `done` is high: ignored. The state is still EXEC/MUL during that cycle and the FSM re-accepts from IDLE on the next cycle.

## Timing
- Accepting edge = E.
- Logic ops, ADD/SUB/SLT: `done`=1 and outputs valid in the cycle after E+1 (latency 2 edges); `busy` is high for the cycles after E and E+1.
- MUL: iterations run on edges E+1..E+32. `done` and outputs are valid after edge E+32 (latency 33 edges).
- Back-to-back throughput:
  - 1 op per 3 cycles (logic/ADD/SUB/SLT).
  - 1 op per 34 cycles (MUL).
- No combinational path from inputs to outputs.

## Structure
- Shared package `alu_defs`:
  - opcode constants (`OP_AND`..`OP_MUL`)
  - FSM state encoding
  - `MUL_CYCLES`=32
- The existing bitwise units and adder are instantiated unchanged; EXEC selects their outputs.
- One sub-module, `shift_add_multiplier`:
  - Holds the accumulator, counter and per-iteration step.
  - Controlled by `load`/`step` signals from the `alu32_seq` FSM.
  - Returns `last` when the count reaches WIDTH-1.

## Test plan
- Reset, then OR with `first`=F114002A, `second`=0000FFF0 → `result`=F114FFFA, `done` 2 edges after accept, `zero`=0.
- AND BAAACC00 & DBB44050 → 9AA04000. Then NOR 0 with FFFFFFFF → `result`=0, `zero`=1.
- ADD 7FFFFFFF+00000001 → 80000000, `overflow`=1. Then SLT FFFFFFFF vs 00000001 → 00000001, `overflow`=0.
- MUL 00010000×00010000 → `result`=0, `result_hi`=00000001, `zero`=0, `done` exactly 33 edges after accept. MUL FFFFFFFF×FFFFFFFF → hi FFFFFFFE, lo 00000001.
- Start a MUL; pulse `start` with op=001 at cycle 10 → ignored, and the MUL result is unchanged. Assert `reset` at cycle 20 of a second MUL → no `done`, all outputs 0, and the next OR completes normally.

Source files
------------

// File: rtl/alu_defs.sv
// Shared definitions for the sequential ALU stage: opcodes, FSM states, multiplier sizing.
package alu_defs;

    localparam int unsigned MUL_CYCLES = 32;
    localparam int unsigned CNT_W      = 6;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_NOR = 3'b011,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101,
        OP_SLT = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } state_e;

endpackage

// File: rtl/adder.sv
// Wrapping adder with carry-in; subtraction is a + ~b + 1.
module adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum
);
    assign sum = a + b + WIDTH'(cin);
endmodule

// File: rtl/my_and.sv
// Bitwise AND unit.
module my_and #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = a & b;
endmodule

// File: rtl/my_nor.sv
// Bitwise NOR unit.
module my_nor #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = ~(a | b);
endmodule

// File: rtl/my_or.sv
// Bitwise OR unit.
module my_or #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = a | b;
endmodule

// File: rtl/my_xor.sv
// Bitwise XOR unit.
module my_xor #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = a ^ b;
endmodule

// File: rtl/shift_add_multiplier.sv
// Unsigned radix-2 shift-add multiplier: one conditional add plus right shift per step.
module shift_add_multiplier
    import alu_defs::*;
#(
    parameter int unsigned WIDTH = MUL_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] prod_hi_c,
    output logic [WIDTH-1:0] prod_lo_c,
    output logic             last
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [WIDTH:0]   sum_c;

    // One iteration: add keeps the carry, which shifts into the top of hi.
    always_comb begin
        sum_c     = (WIDTH+1)'(hi_q) + (lo_q[0] ? (WIDTH+1)'(mcand_q) : (WIDTH+1)'(0));
        prod_hi_c = sum_c[WIDTH:1];
        prod_lo_c = {sum_c[0], lo_q[WIDTH-1:1]};
    end

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (load) begin
            hi_d    = '0;
            lo_d    = multiplier;
            mcand_d = multiplicand;
            cnt_d   = '0;
            last_d  = 1'b0;
        end else if (step) begin
            hi_d   = prod_hi_c;
            lo_d   = prod_lo_c;
            cnt_d  = last_q ? '0 : cnt_q + CNT_W'(1);
            last_d = (cnt_q == CNT_W'(WIDTH - 2));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign last = last_q;

endmodule

// File: rtl/alu32_seq.sv
// Sequential ALU stage: start/done handshake, single-cycle bitwise/arith ops
// and a WIDTH-iteration unsigned multiply, all results registered.
module alu32_seq
    import alu_defs::*;
#(
    parameter int unsigned WIDTH = MUL_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] first,
    input  logic [WIDTH-1:0] second,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             overflow,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    alu_op_e          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] and_c, or_c, xor_c, nor_c, sum_c, add_b_c;
    logic             sub_sel_c, add_ovf_c, slt_c;
    logic [WIDTH-1:0] exec_res_c;
    logic             exec_ovf_c;
    logic             mul_load_c, mul_step_c, mul_last;
    logic [WIDTH-1:0] mul_hi_c, mul_lo_c;

    my_and #(.WIDTH(WIDTH)) u_and (.a(a_q), .b(b_q), .y(and_c));
    my_or  #(.WIDTH(WIDTH)) u_or  (.a(a_q), .b(b_q), .y(or_c));
    my_xor #(.WIDTH(WIDTH)) u_xor (.a(a_q), .b(b_q), .y(xor_c));
    my_nor #(.WIDTH(WIDTH)) u_nor (.a(a_q), .b(b_q), .y(nor_c));

    // SUB and SLT share the adder as a + ~b + 1.
    assign sub_sel_c = (op_q == OP_SUB) || (op_q == OP_SLT);
    assign add_b_c   = sub_sel_c ? ~b_q : b_q;

    adder #(.WIDTH(WIDTH)) u_adder (
        .a   (a_q),
        .b   (add_b_c),
        .cin (sub_sel_c),
        .sum (sum_c)
    );

    // Signed less-than is the difference sign corrected by overflow.
    assign add_ovf_c = (a_q[WIDTH-1] == add_b_c[WIDTH-1]) && (sum_c[WIDTH-1] != a_q[WIDTH-1]);
    assign slt_c     = sum_c[WIDTH-1] ^ add_ovf_c;

    always_comb begin
        exec_res_c = '0;
        exec_ovf_c = 1'b0;
        case (op_q)
            OP_AND: exec_res_c = and_c;
            OP_OR:  exec_res_c = or_c;
            OP_XOR: exec_res_c = xor_c;
            OP_NOR: exec_res_c = nor_c;
            OP_ADD, OP_SUB: begin
                exec_res_c = sum_c;
                exec_ovf_c = add_ovf_c;
            end
            OP_SLT: exec_res_c = WIDTH'(slt_c);
            default: exec_res_c = '0;
        endcase
    end

    shift_add_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk          (clk),
        .reset        (reset),
        .load         (mul_load_c),
        .step         (mul_step_c),
        .multiplicand (first),
        .multiplier   (second),
        .prod_hi_c    (mul_hi_c),
        .prod_lo_c    (mul_lo_c),
        .last         (mul_last)
    );

    // done_q doubles as the "results already loaded" phase of EXEC/MUL.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        mul_load_c  = 1'b0;
        mul_step_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d   = alu_op_e'(alu_op);
                    a_d    = first;
                    b_d    = second;
                    busy_d = 1'b1;
                    if (alu_op_e'(alu_op) == OP_MUL) begin
                        state_d    = ST_MUL;
                        mul_load_c = 1'b1;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (done_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    result_d    = exec_res_c;
                    result_hi_d = '0;
                    overflow_d  = exec_ovf_c;
                    zero_d      = (exec_res_c == '0);
                    done_d      = 1'b1;
                end
            end
            ST_MUL: begin
                if (done_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    mul_step_c = 1'b1;
                    if (mul_last) begin
                        result_d    = mul_lo_c;
                        result_hi_d = mul_hi_c;
                        overflow_d  = 1'b0;
                        zero_d      = (mul_lo_c == '0) && (mul_hi_c == '0);
                        done_d      = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_AND;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_alu32_seq.sv
// Self-checking bench for alu32_seq: directed corner cases plus random ops vs an arithmetic model.
module tb_alu32_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  alu_op;
    logic [31:0] first, second;
    logic [31:0] result, result_hi;
    logic        overflow, zero, busy, done;

    int total = 0;
    int bad   = 0;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 64'sd1;

    always #5 clk = ~clk;

    alu32_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .alu_op    (alu_op),
        .first     (first),
        .second    (second),
        .result    (result),
        .result_hi (result_hi),
        .overflow  (overflow),
        .zero      (zero),
        .busy      (busy),
        .done      (done)
    );

    // Reference: true mathematical results, truncated only where the ALU wraps.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic ov);
        longint      s;
        logic [63:0] p;
        hi = '0;
        lo = '0;
        ov = 1'b0;
        case (op)
            3'd0: lo = a & b;
            3'd1: lo = a | b;
            3'd2: lo = a ^ b;
            3'd3: lo = ~(a | b);
            3'd4: begin
                s  = longint'($signed(a)) + longint'($signed(b));
                lo = a + b;
                ov = (s > SMAX) || (s < SMIN);
            end
            3'd5: begin
                s  = longint'($signed(a)) - longint'($signed(b));
                lo = a - b;
                ov = (s > SMAX) || (s < SMIN);
            end
            3'd6: lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin
                p  = 64'(a) * 64'(b);
                hi = p[63:32];
                lo = p[31:0];
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        alu_op = op;
        first  = a;
        second = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        first  = $urandom;
        second = $urandom;
        alu_op = 3'($urandom);
    endtask

    task automatic wait_done(inout int lat);
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int lat);
        logic [31:0] eh, el;
        logic        eo;
        model(op, a, b, eh, el, eo);
        chk({tag, ".lat"},  64'(lat), (op == 3'd7) ? 64'd33 : 64'd2);
        chk({tag, ".res"},  64'(result), 64'(el));
        chk({tag, ".hi"},   64'(result_hi), 64'(eh));
        chk({tag, ".ovf"},  64'(overflow), 64'(eo));
        chk({tag, ".zero"}, 64'(zero), 64'((el == 32'd0) && (eh == 32'd0)));
        chk({tag, ".busy"}, 64'(busy), 64'd1);
    endtask

    task automatic finish_op(input string tag);
        @(posedge clk);
        #1;
        chk({tag, ".done_drop"}, 64'(done), 64'd0);
        chk({tag, ".idle"},      64'(busy), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        launch(op, a, b);
        lat = 1;
        wait_done(lat);
        check_op(tag, op, a, b, lat);
        finish_op(tag);
    endtask

    initial begin
        logic [31:0] ma, mb, ra, rb;
        logic [2:0]  rop;
        int          lat;
        int          seen;

        reset  = 1'b1;
        start  = 1'b0;
        alu_op = 3'd0;
        first  = '0;
        second = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.res",  64'(result), 64'd0);
        chk("rst.hi",   64'(result_hi), 64'd0);
        chk("rst.ovf",  64'(overflow), 64'd0);
        chk("rst.zero", 64'(zero), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("or", 3'd1, 32'hF114002A, 32'h0000FFF0);
        chk("or.lit", 64'(result), 64'h00000000F114FFFA);
        run_op("and", 3'd0, 32'hBAAACC00, 32'hDBB44050);
        chk("and.lit", 64'(result), 64'h000000009AA04000);
        run_op("nor", 3'd3, 32'h00000000, 32'hFFFFFFFF);
        chk("nor.litz", 64'(zero), 64'd1);
        run_op("add", 3'd4, 32'h7FFFFFFF, 32'h00000001);
        chk("add.lit", 64'({overflow, result}), 64'h0000000180000000);
        run_op("slt", 3'd6, 32'hFFFFFFFF, 32'h00000001);
        chk("slt.lit", 64'({overflow, result}), 64'h0000000000000001);
        run_op("sub", 3'd5, 32'h80000000, 32'h00000001);
        run_op("mul1", 3'd7, 32'h00010000, 32'h00010000);
        chk("mul1.lit", {result_hi, result}, 64'h0000000100000000);
        run_op("mul2", 3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("mul2.lit", {result_hi, result}, 64'hFFFFFFFE00000001);

        // Outputs hold while idle with inputs toggling.
        repeat (5) begin
            @(negedge clk);
            first  = $urandom;
            second = $urandom;
        end
        #1;
        chk("hold", {result_hi, result}, 64'hFFFFFFFE00000001);

        // Start held through the done cycle is ignored there, then accepted from IDLE.
        launch(3'd2, 32'hA5A5F00F, 32'h0FF0A5A5);
        lat = 1;
        wait_done(lat);
        check_op("b2b1", 3'd2, 32'hA5A5F00F, 32'h0FF0A5A5, lat);
        @(negedge clk);
        start  = 1'b1;
        alu_op = 3'd1;
        first  = 32'h12000034;
        second = 32'h00560078;
        @(posedge clk);
        #1;
        chk("b2b.ignored", 64'({busy, done}), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b.accept", 64'(busy), 64'd1);
        lat = 1;
        wait_done(lat);
        check_op("b2b2", 3'd1, 32'h12000034, 32'h00560078, lat);
        finish_op("b2b2");

        // Start during a multiply is dropped without disturbing it.
        ma = $urandom;
        mb = $urandom;
        launch(3'd7, ma, mb);
        lat = 1;
        repeat (8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        start  = 1'b1;
        alu_op = 3'd1;
        first  = $urandom;
        second = $urandom;
        @(posedge clk);
        #1;
        lat++;
        start = 1'b0;
        wait_done(lat);
        check_op("mulign", 3'd7, ma, mb, lat);
        finish_op("mulign");

        // Reset mid-multiply aborts with no done and clears outputs.
        run_op("pre", 3'd2, 32'h12345678, 32'h0F0F0F0F);
        launch(3'd7, 32'hDEADBEEF, 32'h00C0FFEE);
        repeat (18) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort.res",  64'(result), 64'd0);
        chk("abort.hi",   64'(result_hi), 64'd0);
        chk("abort.ovf",  64'(overflow), 64'd0);
        chk("abort.zero", 64'(zero), 64'd0);
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        chk("abort.nodone", 64'(seen), 64'd0);
        run_op("post", 3'd1, 32'hF114002A, 32'h0000FFF0);

        // Random ops, operands biased toward sign/carry boundaries.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: ra = 32'h80000000;
                1: ra = 32'h7FFFFFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: rb = 32'hFFFFFFFF;
                1: rb = ra;
                default: rb = $urandom;
            endcase
            run_op("rnd", rop, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
